// File: rtl/npp_pkg.sv
// Shared encodings, BTB entry layout and counter helper for the next-PC predictor.
package npp_pkg;

    localparam int unsigned KIND_W = 2;

    localparam logic [KIND_W-1:0] KIND_BR   = 2'd0;
    localparam logic [KIND_W-1:0] KIND_J    = 2'd1;
    localparam logic [KIND_W-1:0] KIND_CALL = 2'd2;
    localparam logic [KIND_W-1:0] KIND_RET  = 2'd3;

    // Entry fields are sized for the widest supported configuration; narrower
    // instances zero-extend on write, so the unused upper bits stay constant.
    localparam int unsigned NPP_MAX_ADDR_W = 64;
    localparam int unsigned NPP_MAX_CTR_W  = 8;

    typedef struct packed {
        logic                      valid;
        logic [KIND_W-1:0]         kind;
        logic [NPP_MAX_CTR_W-1:0]  ctr;
        logic [NPP_MAX_ADDR_W-1:0] tag;
        logic [NPP_MAX_ADDR_W-1:0] target;
    } btb_entry_t;

    // Saturating +/-1 step bounded by [0, ctr_max].
    function automatic logic [NPP_MAX_CTR_W-1:0] ctr_step(
        input logic [NPP_MAX_CTR_W-1:0] ctr,
        input logic                     up,
        input logic [NPP_MAX_CTR_W-1:0] ctr_max
    );
        if (up) begin
            return (ctr == ctr_max) ? ctr : ctr + NPP_MAX_CTR_W'(1);
        end
        return (ctr == '0) ? ctr : ctr - NPP_MAX_CTR_W'(1);
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational resolution of a control-flow instruction: real target, outcome and next PC.
module branch_target_calc
    import npp_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] PC_Plus4,
    input  logic [31:0]       Instruction,
    input  logic [ADDR_W-1:0] RegValue,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              JumpReg,
    input  logic              Taken,
    output logic [ADDR_W-1:0] Target,
    output logic              ActualTaken,
    output logic [ADDR_W-1:0] ActualNext
);

    logic [ADDR_W-1:0] br_target_c;
    logic [ADDR_W-1:0] j_target_c;
    logic              unused_opcode_c;

    assign br_target_c = PC_Plus4 + {{(ADDR_W-18){Instruction[15]}}, Instruction[15:0], 2'b00};
    assign j_target_c  = {PC_Plus4[ADDR_W-1:28], Instruction[25:0], 2'b00};

    // Register targets take priority; otherwise the encoding decides.
    always_comb begin
        Target = j_target_c;
        if (JumpReg) begin
            Target = RegValue;
        end else if (Branch) begin
            Target = br_target_c;
        end
    end

    assign ActualTaken = Jump | (Branch & Taken);
    assign ActualNext  = ActualTaken ? Target : PC_Plus4 + ADDR_W'(4);

    assign unused_opcode_c = ^Instruction[31:26];

endmodule

// File: rtl/next_pc_predictor.sv
// Next-fetch-address predictor: BTB + saturating counters + RAS, with resolve-time
// update, registered redirect on mispredict and lookup/mispredict statistics.
module next_pc_predictor
    import npp_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CTR_W       = 2,
    parameter int unsigned RAS_DEPTH   = 4,
    parameter int unsigned STAT_W      = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Fetch_Valid,
    input  logic [ADDR_W-1:0] Fetch_PC,
    output logic              Pred_Taken,
    output logic [ADDR_W-1:0] Pred_Target,
    input  logic              Res_Valid,
    input  logic [1:0]        Res_Kind,
    input  logic              Res_JumpReg,
    input  logic [ADDR_W-1:0] Res_PC_Plus4,
    input  logic [31:0]       Res_Instruction,
    input  logic [ADDR_W-1:0] Res_RegValue,
    input  logic              Res_Taken,
    input  logic              Res_Pred_Taken,
    input  logic [ADDR_W-1:0] Res_Pred_Target,
    output logic              Redirect_Valid,
    output logic [ADDR_W-1:0] Redirect_PC,
    output logic [STAT_W-1:0] Stat_Lookups,
    output logic [STAT_W-1:0] Stat_Mispredicts
);

    localparam int unsigned IDX_W     = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W     = ADDR_W - IDX_W - 2;
    localparam int unsigned RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [NPP_MAX_CTR_W-1:0] CTR_WEAK = NPP_MAX_CTR_W'(1) << (CTR_W - 1);
    localparam logic [NPP_MAX_CTR_W-1:0] CTR_MAX  = NPP_MAX_CTR_W'((1 << CTR_W) - 1);

    btb_entry_t        btb_q [BTB_ENTRIES];
    btb_entry_t        btb_d [BTB_ENTRIES];
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [RAS_CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic              redir_valid_q, redir_valid_d;
    logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
    logic [STAT_W-1:0] stat_lookups_q, stat_lookups_d;
    logic [STAT_W-1:0] stat_mis_q, stat_mis_d;

    logic [RAS_PTR_W-1:0] ras_top_idx_c;
    logic [RAS_PTR_W-1:0] ras_ptr_inc_c;

    assign ras_top_idx_c = (ras_ptr_q == '0) ? RAS_PTR_W'(RAS_DEPTH - 1) : ras_ptr_q - RAS_PTR_W'(1);
    assign ras_ptr_inc_c = (ras_ptr_q == RAS_PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + RAS_PTR_W'(1);

    // Fetch-side lookup against the registered tables only.
    logic [IDX_W-1:0]  f_idx_c;
    logic [TAG_W-1:0]  f_tag_c;
    btb_entry_t        f_ent_c;
    logic              f_hit_c;
    logic              pred_taken_c;
    logic [ADDR_W-1:0] pred_target_c;

    assign f_idx_c = Fetch_PC[IDX_W+1:2];
    assign f_tag_c = Fetch_PC[ADDR_W-1:IDX_W+2];
    assign f_ent_c = btb_q[f_idx_c];
    assign f_hit_c = f_ent_c.valid && (f_ent_c.tag == NPP_MAX_ADDR_W'(f_tag_c));

    always_comb begin
        pred_taken_c  = 1'b0;
        pred_target_c = Fetch_PC + ADDR_W'(4);
        if (f_hit_c) begin
            pred_taken_c = (f_ent_c.kind == KIND_BR) ? f_ent_c.ctr[CTR_W-1] : 1'b1;
            if (pred_taken_c) begin
                if (f_ent_c.kind == KIND_RET && ras_cnt_q != '0) begin
                    pred_target_c = ras_q[ras_top_idx_c];
                end else begin
                    pred_target_c = ADDR_W'(f_ent_c.target);
                end
            end
        end
    end

    assign Pred_Taken  = pred_taken_c;
    assign Pred_Target = pred_target_c;

    // Resolve side: the entry is addressed by the instruction's own PC.
    logic [ADDR_W-1:0] res_pc_c;
    logic [IDX_W-1:0]  r_idx_c;
    logic [TAG_W-1:0]  r_tag_c;
    btb_entry_t        r_ent_c;
    logic              r_hit_c;
    logic              is_br_c;
    logic [ADDR_W-1:0] act_target_c;
    logic              act_taken_c;
    logic [ADDR_W-1:0] act_next_c;
    logic              mispredict_c;
    logic              unused_pc_lsb_c;

    assign res_pc_c = Res_PC_Plus4 - ADDR_W'(4);
    assign r_idx_c  = res_pc_c[IDX_W+1:2];
    assign r_tag_c  = res_pc_c[ADDR_W-1:IDX_W+2];
    assign r_ent_c  = btb_q[r_idx_c];
    assign r_hit_c  = r_ent_c.valid && (r_ent_c.tag == NPP_MAX_ADDR_W'(r_tag_c));
    assign is_br_c  = (Res_Kind == KIND_BR);

    assign unused_pc_lsb_c = ^{Fetch_PC[1:0], res_pc_c[1:0]};

    branch_target_calc #(
        .ADDR_W (ADDR_W)
    ) u_calc (
        .PC_Plus4    (Res_PC_Plus4),
        .Instruction (Res_Instruction),
        .RegValue    (Res_RegValue),
        .Branch      (is_br_c),
        .Jump        (!is_br_c),
        .JumpReg     (Res_JumpReg),
        .Taken       (Res_Taken),
        .Target      (act_target_c),
        .ActualTaken (act_taken_c),
        .ActualNext  (act_next_c)
    );

    assign mispredict_c = Res_Valid &&
                          ((Res_Pred_Taken != act_taken_c) ||
                           (act_taken_c && (Res_Pred_Target != act_target_c)));

    // Next-state for tables, RAS, redirect and statistics.
    always_comb begin
        btb_d          = btb_q;
        ras_d          = ras_q;
        ras_ptr_d      = ras_ptr_q;
        ras_cnt_d      = ras_cnt_q;
        redir_valid_d  = mispredict_c;
        redir_pc_d     = mispredict_c ? act_next_c : redir_pc_q;
        stat_lookups_d = stat_lookups_q + STAT_W'(Fetch_Valid);
        stat_mis_d     = stat_mis_q + STAT_W'(mispredict_c);

        if (Res_Valid) begin
            if (r_hit_c) begin
                if (is_br_c) begin
                    btb_d[r_idx_c].ctr = ctr_step(r_ent_c.ctr, Res_Taken, CTR_MAX);
                end
                btb_d[r_idx_c].target = NPP_MAX_ADDR_W'(act_target_c);
                btb_d[r_idx_c].kind   = Res_Kind;
            end else if (act_taken_c) begin
                btb_d[r_idx_c] = '{valid:  1'b1,
                                   kind:   Res_Kind,
                                   ctr:    CTR_WEAK,
                                   tag:    NPP_MAX_ADDR_W'(r_tag_c),
                                   target: NPP_MAX_ADDR_W'(act_target_c)};
            end

            // A full stack wraps onto its oldest slot, so the count saturates.
            if (Res_Kind == KIND_CALL) begin
                ras_d[ras_ptr_q] = Res_PC_Plus4 + ADDR_W'(4);
                ras_ptr_d        = ras_ptr_inc_c;
                if (ras_cnt_q != RAS_CNT_W'(RAS_DEPTH)) begin
                    ras_cnt_d = ras_cnt_q + RAS_CNT_W'(1);
                end
            end else if (Res_Kind == KIND_RET && ras_cnt_q != '0) begin
                ras_ptr_d = ras_top_idx_c;
                ras_cnt_d = ras_cnt_q - RAS_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            btb_q          <= '{default: '0};
            ras_q          <= '{default: '0};
            ras_ptr_q      <= '0;
            ras_cnt_q      <= '0;
            redir_valid_q  <= 1'b0;
            redir_pc_q     <= '0;
            stat_lookups_q <= '0;
            stat_mis_q     <= '0;
        end else begin
            btb_q          <= btb_d;
            ras_q          <= ras_d;
            ras_ptr_q      <= ras_ptr_d;
            ras_cnt_q      <= ras_cnt_d;
            redir_valid_q  <= redir_valid_d;
            redir_pc_q     <= redir_pc_d;
            stat_lookups_q <= stat_lookups_d;
            stat_mis_q     <= stat_mis_d;
        end
    end

    assign Redirect_Valid   = redir_valid_q;
    assign Redirect_PC      = redir_pc_q;
    assign Stat_Lookups     = stat_lookups_q;
    assign Stat_Mispredicts = stat_mis_q;

endmodule
